mtx_period_gen: RTL and testbench

//  Generates the periodic MTX test signal from a BCD period setpoint in 0.1 us ticks (ce01us).
//  The setpoint has a 4-decade integer part and an optional 4-decade fraction.
//  It is the source end of the MTX period-measurement chain, used for stimulus and self-test of the period meter.
//  A fractional BCD accumulator dithers period length so the mean period equals QSET.FSET ticks.

---
 rtl/mtx_period_gen.sv | 181 ++++++++++++++++++
 tb/tb_mtx_period_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_period_gen.sv
// MTX test-signal generator: BCD period setpoint in 0.1 us ticks, with window counter.
// Define MTX_GEN_FRAC_EN to enable the fractional BCD accumulator that dithers period length.
module mtx_period_gen #(
  parameter int M    = 1000,
  parameter int QMIN = 2
) (
  input  logic        clk,
  input  logic        R,
  input  logic        ce01us,
  input  logic        en,
  input  logic        ld,
  input  logic [15:0] QSET,
  input  logic [15:0] FSET,
  output logic        MTX,
  output logic        ceP,
  output logic        ceMT,
  output logic [9:0]  cb_MT,
  output logic        err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [13:0] k_q, k_d;
  logic [13:0] len_q, len_d;
  logic        mtx_q, mtx_d;
  logic        cep_q, cep_d;
  logic        cemt_q, cemt_d;
  logic [9:0]  cb_q, cb_d;
  logic        err_q, err_d;
  logic [13:0] shadow_qb_q, shadow_qb_d;

  logic [7:0]  nib_ok;
  logic [13:0] qset_bin;
  logic        load_ok;
  logic        shadow_valid;
  logic        period_start;
  logic [13:0] len_start;
  logic [13:0] half_len;
  logic [13:0] k_inc;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_ok[gi]   = (QSET[4*gi+3:4*gi] <= 4'd9);
      assign nib_ok[gi+4] = (FSET[4*gi+3:4*gi] <= 4'd9);
    end
  endgenerate

  assign qset_bin = 14'(QSET[15:12]) * 14'd1000 + 14'(QSET[11:8]) * 14'd100
                  + 14'(QSET[7:4]) * 14'd10 + 14'(QSET[3:0]);
  assign load_ok      = (&nib_ok) && (qset_bin >= 14'(QMIN));
  assign shadow_valid = (shadow_qb_q >= 14'(QMIN));

`ifdef MTX_GEN_FRAC_EN
  logic [15:0] shadow_f_q, shadow_f_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] acc_sum;
  logic [4:0]  dcarry;

  // Decimal ripple adder: each digit wraps at 10 and carries into the next decade.
  assign dcarry[0] = 1'b0;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcd_add
      logic [4:0] raw;
      assign raw = {1'b0, acc_q[4*gi+3:4*gi]} + {1'b0, shadow_f_q[4*gi+3:4*gi]}
                 + {4'b0, dcarry[gi]};
      assign dcarry[gi+1] = (raw > 5'd9);
      assign acc_sum[4*gi+3:4*gi] = (raw > 5'd9) ? 4'(raw - 5'd10) : raw[3:0];
    end
  endgenerate

  assign len_start = shadow_qb_q + 14'(dcarry[4]);
`else
  assign len_start = shadow_qb_q;
`endif

  assign half_len = 14'((len_q + 14'd1) >> 1);
  assign k_inc    = k_q + 14'd1;

  // The period boundary always uses the registered shadow, so a coincident ld lands one period later.
  assign period_start = en && ce01us &&
                        (((state_q == ST_IDLE) && shadow_valid) ||
                         ((state_q == ST_RUN) && (k_inc == len_q)));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    len_d       = len_q;
    mtx_d       = mtx_q;
    cep_d       = 1'b0;
    cemt_d      = 1'b0;
    cb_d        = cb_q;
    err_d       = err_q;
    shadow_qb_d = shadow_qb_q;
`ifdef MTX_GEN_FRAC_EN
    shadow_f_d  = shadow_f_q;
    acc_d       = acc_q;
`endif

    if (ld) begin
      if (load_ok) begin
        shadow_qb_d = qset_bin;
`ifdef MTX_GEN_FRAC_EN
        shadow_f_d  = FSET;
`endif
        err_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    if ((state_q == ST_RUN) && !en) begin
      state_d = ST_IDLE;
      k_d     = '0;
      mtx_d   = 1'b0;
      cb_d    = '0;
`ifdef MTX_GEN_FRAC_EN
      acc_d   = '0;
`endif
    end else if (period_start) begin
      state_d = ST_RUN;
      k_d     = '0;
      len_d   = len_start;
      mtx_d   = 1'b1;
      cep_d   = 1'b1;
`ifdef MTX_GEN_FRAC_EN
      acc_d   = acc_sum;
`endif
      if (cb_q == 10'(M)) begin
        cb_d   = 10'd1;
        cemt_d = 1'b1;
      end else begin
        cb_d = cb_q + 10'd1;
      end
    end else if ((state_q == ST_RUN) && ce01us) begin
      k_d   = k_inc;
      mtx_d = (k_inc < half_len);
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      len_q       <= '0;
      mtx_q       <= 1'b0;
      cep_q       <= 1'b0;
      cemt_q      <= 1'b0;
      cb_q        <= '0;
      err_q       <= 1'b0;
      shadow_qb_q <= '0;
`ifdef MTX_GEN_FRAC_EN
      shadow_f_q  <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      len_q       <= len_d;
      mtx_q       <= mtx_d;
      cep_q       <= cep_d;
      cemt_q      <= cemt_d;
      cb_q        <= cb_d;
      err_q       <= err_d;
      shadow_qb_q <= shadow_qb_d;
`ifdef MTX_GEN_FRAC_EN
      shadow_f_q  <= shadow_f_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign MTX   = mtx_q;
  assign ceP   = cep_q;
  assign ceMT  = cemt_q;
  assign cb_MT = cb_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mtx_period_gen.sv
// Directed bench for mtx_period_gen with a 4-period window; expectations follow MTX_GEN_FRAC_EN.
module tb_mtx_period_gen;

  logic        clk = 1'b0;
  logic        R, ce01us, en, ld;
  logic [15:0] QSET, FSET;
  logic        MTX, ceP, ceMT, err;
  logic [9:0]  cb_MT;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef MTX_GEN_FRAC_EN
  localparam int SUM20  = 210;
  localparam int HI20   = 110;
  localparam int L2_EXP = 11;
  localparam int BIGLEN = 10000;
`else
  localparam int SUM20  = 200;
  localparam int HI20   = 100;
  localparam int L2_EXP = 10;
  localparam int BIGLEN = 9999;
`endif

  mtx_period_gen #(.M(4), .QMIN(2)) dut (
    .clk(clk), .R(R), .ce01us(ce01us), .en(en), .ld(ld),
    .QSET(QSET), .FSET(FSET),
    .MTX(MTX), .ceP(ceP), .ceMT(ceMT), .cb_MT(cb_MT), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    ce01us = 1'b1;
    @(posedge clk);
    #1;
    ce01us = 1'b0;
  endtask

  task automatic load(input logic [15:0] q, input logic [15:0] f, input logic with_ce);
    @(negedge clk);
    QSET = q;
    FSET = f;
    ld = 1'b1;
    ce01us = with_ce;
    @(posedge clk);
    #1;
    ld = 1'b0;
    ce01us = 1'b0;
  endtask

  // Continues counting ticks until the next period start; leaves the bench at its k=0.
  task automatic finish_period(inout int len, inout int hi);
    bit done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      tick();
      if (ceP) done = 1'b1;
      else begin
        len++;
        hi += int'(MTX);
      end
    end
    if (!done) begin
      n_cmp++;
      n_mis++;
      $error("FAIL period_timeout: observed no ceP expected ceP within 20000 ticks");
    end
  endtask

  task automatic run_period(output int len, output int hi);
    len = 1;
    hi  = int'(MTX);
    finish_period(len, hi);
  endtask

  initial begin
    int l, h, l1, l2, sl, sh, seen;
    R = 1'b1; ce01us = 1'b0; en = 1'b0; ld = 1'b0; QSET = '0; FSET = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mtx", MTX, 0);
    chk("rst_cep", ceP, 0);
    chk("rst_cemt", ceMT, 0);
    chk("rst_cb", cb_MT, 0);
    chk("rst_err", err, 0);
    @(negedge clk); R = 1'b0;

    // No valid shadow yet: must stay idle
    en = 1'b1;
    seen = 0;
    repeat (5) begin tick(); seen += int'(ceP) + int'(MTX); end
    chk("idle_noshadow", seen, 0);

    load(16'h0010, 16'h0000, 1'b0);
    chk("ld10_err", err, 0);
    tick();
    chk("s1_cep", ceP, 1);
    chk("s1_mtx", MTX, 1);
    chk("s1_cb", cb_MT, 1);
    run_period(l, h);
    chk("p10_len", l, 10);
    chk("p10_hi", h, 5);
    chk("s2_cb", cb_MT, 2);
    run_period(l, h);
    run_period(l, h);
    chk("s4_cb", cb_MT, 4);
    chk("s4_cemt", ceMT, 0);
    run_period(l, h);
    chk("s5_cemt", ceMT, 1);
    chk("s5_cb", cb_MT, 1);

    // Rejected loads
    load(16'h00A0, 16'h0000, 1'b0);
    chk("bad_digit_err", err, 1);
    load(16'h0001, 16'h0000, 1'b0);
    chk("below_qmin_err", err, 1);
    load(16'h0010, 16'h00A0, 1'b0);
    chk("bad_fset_err", err, 1);
    run_period(l, h);
    chk("keep_len", l, 10);
    load(16'h0003, 16'h0000, 1'b0);
    chk("good_ld_clr_err", err, 0);
    run_period(l, h);
    chk("cur_period_len", l, 10);
    run_period(l, h);
    chk("p3_len", l, 3);
    chk("p3_hi", h, 2);
    run_period(l, h);
    chk("s9_cemt", ceMT, 1);
    chk("s9_cb", cb_MT, 1);

    // Mid-period load at k=4
    load(16'h0010, 16'h0000, 1'b0);
    run_period(l, h);
    chk("p3_again", l, 3);
    l = 1; h = int'(MTX);
    repeat (4) begin tick(); l++; h += int'(MTX); end
    load(16'h0020, 16'h0000, 1'b0);
    finish_period(l, h);
    chk("mid_ld_len", l, 10);
    chk("mid_ld_hi", h, 5);

    // Load coincident with the period-start tick
    l = 1;
    repeat (19) begin tick(); l++; end
    chk("p20_no_early_cep", ceP, 0);
    chk("p20_count", l, 20);
    load(16'h0010, 16'h0000, 1'b1);
    chk("coinc_cep", ceP, 1);
    run_period(l, h);
    chk("coinc_old_len", l, 20);
    chk("coinc_old_hi", h, 10);
    run_period(l, h);
    chk("coinc_new_len", l, 10);

    // Fractional setpoint 10.5
    load(16'h0010, 16'h5000, 1'b0);
    run_period(l, h);
    chk("frac_cur_len", l, 10);
    sl = 0; sh = 0; l1 = 0; l2 = 0;
    for (int p = 0; p < 20; p++) begin
      run_period(l, h);
      if (p == 0) l1 = l;
      if (p == 1) l2 = l;
      sl += l;
      sh += h;
    end
    chk("frac_l1", l1, 10);
    chk("frac_l2", l2, L2_EXP);
    chk("frac_sum20", sl, SUM20);
    chk("frac_hi20", sh, HI20);

    // Largest setpoint with carry: 9999 + cy
    load(16'h9999, 16'h9999, 1'b0);
    run_period(l, h);
    chk("pre_big_len", l, 10);
    run_period(l, h);
    chk("big_len", l, BIGLEN);
    chk("big_hi", h, 5000);

    // en=0 returns to idle and ignores ticks
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("en0_mtx", MTX, 0);
    chk("en0_cb", cb_MT, 0);
    load(16'h0010, 16'h0000, 1'b0);
    seen = 0;
    repeat (3) begin tick(); seen += int'(ceP) + int'(MTX); end
    chk("en0_ignore_ce", seen, 0);
    en = 1'b1;
    tick();
    chk("restart_cep", ceP, 1);
    chk("restart_cb", cb_MT, 1);
    repeat (7) tick();
    chk("k7_mtx", MTX, 0);
    load(16'h00A0, 16'h0000, 1'b0);
    chk("pre_r_err", err, 1);

    // Reset mid-run
    @(negedge clk); R = 1'b1;
    @(posedge clk); #1;
    chk("r_mtx", MTX, 0);
    chk("r_cep", ceP, 0);
    chk("r_cemt", ceMT, 0);
    chk("r_cb", cb_MT, 0);
    chk("r_err", err, 0);
    @(negedge clk); R = 1'b0;
    seen = 0;
    repeat (5) begin tick(); seen += int'(ceP) + int'(MTX); end
    chk("post_r_idle", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
